ms_path_checker: RTL and testbench
==================================

Name: ms_path_checker

Overview:
- Receiving end of the maze solver's output protocol. Used as a bench-side and on-chip self-check partner for the solver.
- Snoops the same serial maze stream the solver receives, stores the 15x15 map, then consumes the solver's path stream (out_valid/out_x/out_y) or its maze_not_valid pulse.
- Checks that the path is a legal start-to-goal walk through open cells and reports a registered verdict with an error code and the path length.

Parameters:
- N, 15, maze side length; the map holds N*N = 225 cells.
- START_X, 1, start column
- START_Y, 1, start row
- GOAL_X, 13, goal column
- GOAL_Y, 13, goal row
- TIMEOUT, 4096, maximum cycles between the end of maze load and the first output beat

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  maze bit valid (snooped from solver input)
- maze  input  1  maze bit: 1 = wall, 0 = open
- out_valid  input  1  solver path beat valid
- maze_not_valid  input  1  solver claims no path exists (1-cycle pulse)
- out_x  input  4  path beat column
- out_y  input  4  path beat row
- done  output  1  verdict strobe, 1-cycle pulse
- pass  output  1  path legal; valid when done=1, held until next done
- err_code  output  4  first error detected; held until next done
- path_len  output  8  number of path beats, saturates at 255; held until next done

Behaviour:
- Reset (asynchronous, any state): done=0, pass=0, err_code=0, path_len=0; map, visited bitmap and counters cleared; state=LOAD.
- Maze bit order: raster, row-major. Bit k goes to x = k mod 15, y = k div 15. x and y are kept as separate wrap counters; no divider.
- States:
  - LOAD: store maze on each in_valid cycle. The 225th bit moves to WAIT. Gaps in in_valid are allowed. out_valid or maze_not_valid in LOAD -> err 9 (PROTO), go to REPORT.
  - WAIT: count idle cycles.
    - maze_not_valid -> err 7 (UNSOLV), REPORT.
    - out_valid -> the first beat is checked here, go to CHECK.
    - Count reaches TIMEOUT -> err 8 (TIMEOUT), REPORT.
    - in_valid -> err 9, REPORT.
  - CHECK: every out_valid=1 cycle is one beat. The first cycle with out_valid=0 moves to REPORT. maze_not_valid or in_valid during CHECK -> err 9.
  - REPORT: one cycle. Register the verdict: done=1 on the following clock edge. Then return to LOAD with the map, visited bitmap and counters cleared.
- Per-beat checks, first failing check wins in this priority order:
  - 2 RANGE: x >= 15 or y >= 15
  - 1 START: first beat is not (START_X, START_Y)
  - 3 WALL: map[y][x] = 1
  - 4 STEP: |dx| + |dy| != 1 relative to the previous beat (not applied to the first beat)
  - 5 REVISIT: cell already in the visited bitmap
- Visited bit is set for every in-range beat.
- End check: on leaving CHECK, if no error is latched and the last beat is not (GOAL_X, GOAL_Y) -> 6 END.
- Only the first error is latched. Later beats are still consumed and counted.
- Verdict: pass = (err_code == 0). path_len counts all beats, including bad ones, and saturates at 255.
- Latency: done rises 2 cycles after the last beat (1 cycle to detect out_valid=0, 1 registered REPORT).
- Error code summary: 0 OK, 1 START, 2 RANGE, 3 WALL, 4 STEP, 5 REVISIT, 6 END, 7 UNSOLV, 8 TIMEOUT, 9 PROTO, 10-15 reserved.

Test Plan:
- Maze with only the border walls; legal path (1,1)->(1,2)->...->(1,13)->(2,13)->...->(13,13), 25 beats -> done pulse 2 cycles after the last beat, pass=1, err_code=0, path_len=25.
- Same maze, but the 5th beat is a cell whose map bit is 1 -> pass=0, err_code=3, path_len equals the full beat count.
- Diagonal step (3,1)->(4,2) -> err_code=4. First beat (2,1) -> err_code=1. Beat out_x=15 -> err_code=2.
- Path ends at (12,13); separately, a path revisits (2,1) -> err_code=6 and err_code=5 respectively. Two-error path -> only the first error is reported.
- maze_not_valid pulse after the load -> done, pass=0, err_code=7, path_len=0. No output for 4096 cycles -> err_code=8.
- rst_n asserted mid-path (beat 10) -> outputs 0 immediately. Then a fresh legal maze plus path -> pass=1 with correct path_len, with no state carried over. in_valid during CHECK -> err_code=9.

Source files
------------

// File: rtl/ms_path_checker.sv
// Maze-solver output checker: snoops the serial maze load, then validates
// the solver's path stream or its no-path claim and reports a verdict.
module ms_path_checker #(
   parameter int N       = 15,
   parameter int START_X = 1,
   parameter int START_Y = 1,
   parameter int GOAL_X  = 13,
   parameter int GOAL_Y  = 13,
   parameter int TIMEOUT = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       maze,
   input  logic       out_valid,
   input  logic       maze_not_valid,
   input  logic [3:0] out_x,
   input  logic [3:0] out_y,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_code,
   output logic [7:0] path_len
);

   localparam int CELLS = N * N;
   localparam int CW    = $clog2(TIMEOUT + 1);

   localparam logic [3:0] E_OK      = 4'd0;
   localparam logic [3:0] E_START   = 4'd1;
   localparam logic [3:0] E_RANGE   = 4'd2;
   localparam logic [3:0] E_WALL    = 4'd3;
   localparam logic [3:0] E_STEP    = 4'd4;
   localparam logic [3:0] E_REVISIT = 4'd5;
   localparam logic [3:0] E_END     = 4'd6;
   localparam logic [3:0] E_UNSOLV  = 4'd7;
   localparam logic [3:0] E_TIMEOUT = 4'd8;
   localparam logic [3:0] E_PROTO   = 4'd9;

   typedef enum logic [1:0] {
      S_LOAD,
      S_WAIT,
      S_CHECK,
      S_REPORT
   } state_t;

   state_t           r_state;
   logic [CELLS-1:0] r_map;
   logic [CELLS-1:0] r_vis;
   logic [3:0]       r_lx;
   logic [3:0]       r_ly;
   logic [3:0]       r_px;
   logic [3:0]       r_py;
   logic [3:0]       r_err;
   logic [7:0]       r_len;
   logic [CW-1:0]    r_cnt;

   logic [7:0] w_lidx;
   logic [7:0] w_bidx;
   logic       w_inr;
   logic       w_wall;
   logic       w_seen;
   logic       w_first;
   logic [3:0] w_dx;
   logic [3:0] w_dy;
   logic [4:0] w_dist;
   logic [3:0] w_berr;
   logic       w_beat;
   logic       w_at_goal;
   logic       w_proto;
   logic [7:0] w_len_nx;

   assign w_lidx  = 8'(r_ly) * 8'(N) + 8'(r_lx);
   assign w_bidx  = 8'(out_y) * 8'(N) + 8'(out_x);
   assign w_inr   = (out_x < 4'(N)) && (out_y < 4'(N));
   assign w_wall  = w_inr && r_map[w_bidx];
   assign w_seen  = w_inr && r_vis[w_bidx];
   assign w_first = (r_state == S_WAIT);
   assign w_dx    = (out_x >= r_px) ? out_x - r_px : r_px - out_x;
   assign w_dy    = (out_y >= r_py) ? out_y - r_py : r_py - out_y;
   assign w_dist  = {1'b0, w_dx} + {1'b0, w_dy};
   assign w_proto = in_valid || maze_not_valid;

   assign w_at_goal = (r_px == 4'(GOAL_X)) && (r_py == 4'(GOAL_Y));
   assign w_len_nx  = (r_len == 8'hFF) ? r_len : r_len + 8'd1;

   // A no-path claim in WAIT wins over a simultaneous beat.
   assign w_beat = out_valid &&
                   ((r_state == S_CHECK) ||
                    (r_state == S_WAIT && !maze_not_valid));

   always_comb begin
      w_berr = E_OK;
      if (!w_inr)
         w_berr = E_RANGE;
      else if (w_first && (out_x != 4'(START_X) || out_y != 4'(START_Y)))
         w_berr = E_START;
      else if (w_wall)
         w_berr = E_WALL;
      else if (!w_first && w_dist != 5'd1)
         w_berr = E_STEP;
      else if (w_seen)
         w_berr = E_REVISIT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_LOAD;
         r_map    <= '0;
         r_vis    <= '0;
         r_lx     <= '0;
         r_ly     <= '0;
         r_px     <= '0;
         r_py     <= '0;
         r_err    <= E_OK;
         r_len    <= '0;
         r_cnt    <= '0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_code <= '0;
         path_len <= '0;
      end else begin
         done <= 1'b0;
         if (w_beat) begin
            r_len <= w_len_nx;
            r_px  <= out_x;
            r_py  <= out_y;
            if (w_inr)
               r_vis[w_bidx] <= 1'b1;
            if (r_err == E_OK && w_berr != E_OK)
               r_err <= w_berr;
         end
         unique case (r_state)
            S_LOAD: begin
               if (out_valid || maze_not_valid) begin
                  r_err   <= E_PROTO;
                  r_state <= S_REPORT;
               end else if (in_valid) begin
                  r_map[w_lidx] <= maze;
                  if (r_lx == 4'(N - 1)) begin
                     r_lx <= '0;
                     if (r_ly == 4'(N - 1)) begin
                        r_ly    <= '0;
                        r_state <= S_WAIT;
                     end else begin
                        r_ly <= r_ly + 4'd1;
                     end
                  end else begin
                     r_lx <= r_lx + 4'd1;
                  end
               end
            end
            S_WAIT: begin
               if (maze_not_valid) begin
                  r_err   <= E_UNSOLV;
                  r_state <= S_REPORT;
               end else if (out_valid) begin
                  r_state <= S_CHECK;
               end else if (in_valid) begin
                  r_err   <= E_PROTO;
                  r_state <= S_REPORT;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_err   <= E_TIMEOUT;
                  r_state <= S_REPORT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_CHECK: begin
               if (out_valid) begin
                  if (r_err == E_OK && w_berr == E_OK && w_proto)
                     r_err <= E_PROTO;
               end else begin
                  if (r_err == E_OK) begin
                     if (w_proto)
                        r_err <= E_PROTO;
                     else if (!w_at_goal)
                        r_err <= E_END;
                  end
                  r_state <= S_REPORT;
               end
            end
            S_REPORT: begin
               done     <= 1'b1;
               pass     <= (r_err == E_OK);
               err_code <= r_err;
               path_len <= r_len;
               r_map    <= '0;
               r_vis    <= '0;
               r_lx     <= '0;
               r_ly     <= '0;
               r_px     <= '0;
               r_py     <= '0;
               r_err    <= E_OK;
               r_len    <= '0;
               r_cnt    <= '0;
               r_state  <= S_LOAD;
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_ms_path_checker.sv
// Scoreboard bench for ms_path_checker: directed mazes and paths with
// hand-computed verdicts checked by an independent monitor on done.
module tb_ms_path_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       maze = 1'b0;
   logic       out_valid = 1'b0;
   logic       maze_not_valid = 1'b0;
   logic [3:0] out_x = '0;
   logic [3:0] out_y = '0;
   logic       done;
   logic       pass;
   logic [3:0] err_code;
   logic [7:0] path_len;

   ms_path_checker dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .maze          (maze),
      .out_valid     (out_valid),
      .maze_not_valid(maze_not_valid),
      .out_x         (out_x),
      .out_y         (out_y),
      .done          (done),
      .pass          (pass),
      .err_code      (err_code),
      .path_len      (path_len)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit p;
      int err;
      int len;
      int at;
      bit timed;
   } exp_t;

   typedef struct {
      int x;
      int y;
   } pt_t;

   exp_t q[$];
   exp_t me;
   pt_t  path[$];
   int   checks = 0;
   int   errors = 0;

   logic [224:0] mb;
   logic [224:0] mw;
   int lc;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done err=%0d len=%0d", err_code, path_len);
         end else begin
            me = q.pop_front();
            chk("pass", int'(pass), int'(me.p));
            chk("err_code", int'(err_code), me.err);
            chk("path_len", int'(path_len), me.len);
            if (me.timed)
               chk("latency", cyc, me.at);
         end
      end
   end

   task automatic push(input bit p, input int err, input int len,
                       input int at, input bit timed);
      exp_t e;
      e.p = p;
      e.err = err;
      e.len = len;
      e.at = at;
      e.timed = timed;
      q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending=%0d", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic load(input logic [224:0] mm);
      for (int k = 0; k < 225; k++) begin
         if (k % 37 == 36) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         maze = mm[k];
         @(negedge clk);
      end
      in_valid = 1'b0;
      maze = 1'b0;
   endtask

   // Drives up to nmax beats; lastc is the cycle count just after the
   // last beat was sampled.
   task automatic send(input int inv_at, input int nmax, output int lastc);
      lastc = cyc;
      for (int i = 0; i < path.size() && i < nmax; i++) begin
         out_valid = 1'b1;
         out_x = 4'(path[i].x);
         out_y = 4'(path[i].y);
         in_valid = (i == inv_at);
         @(negedge clk);
         lastc = cyc;
      end
      out_valid = 1'b0;
      in_valid = 1'b0;
   endtask

   function automatic void add(input int x, input int y);
      pt_t p;
      p.x = x;
      p.y = y;
      path.push_back(p);
   endfunction

   function automatic void legal();
      path.delete();
      for (int y = 1; y <= 13; y++) add(1, y);
      for (int x = 2; x <= 13; x++) add(x, 13);
   endfunction

   initial begin
      for (int y = 0; y < 15; y++)
         for (int x = 0; x < 15; x++)
            mb[y*15+x] = (x == 0 || x == 14 || y == 0 || y == 14);

      #2 rst_n = 1'b0;
      #1;
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_err", int'(err_code), 0);
      chk("rst_len", int'(path_len), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // beat during load
      out_valid = 1'b1;
      out_x = 4'd1;
      out_y = 4'd1;
      @(negedge clk);
      out_valid = 1'b0;
      push(0, 9, 0, 0, 0);
      drain();

      load(mb);
      legal();
      send(-1, 1000, lc);
      push(1, 0, 25, lc + 2, 1);
      drain();

      mw = mb;
      mw[5*15+1] = 1'b1;
      load(mw);
      legal();
      send(-1, 1000, lc);
      push(0, 3, 25, lc + 2, 1);
      drain();

      load(mb);
      path.delete();
      add(1, 1); add(2, 1); add(3, 1); add(4, 2);
      send(-1, 1000, lc);
      push(0, 4, 4, lc + 2, 1);
      drain();

      load(mb);
      path.delete();
      add(2, 1); add(3, 1);
      send(-1, 1000, lc);
      push(0, 1, 2, lc + 2, 1);
      drain();

      load(mb);
      path.delete();
      add(1, 1); add(15, 1);
      send(-1, 1000, lc);
      push(0, 2, 2, lc + 2, 1);
      drain();

      load(mb);
      legal();
      void'(path.pop_back());
      send(-1, 1000, lc);
      push(0, 6, 24, lc + 2, 1);
      drain();

      load(mb);
      path.delete();
      add(1, 1); add(2, 1); add(3, 1); add(2, 1);
      send(-1, 1000, lc);
      push(0, 5, 4, lc + 2, 1);
      drain();

      load(mb);
      path.delete();
      add(1, 1); add(3, 1); add(3, 0);
      send(-1, 1000, lc);
      push(0, 4, 3, lc + 2, 1);
      drain();

      load(mb);
      maze_not_valid = 1'b1;
      @(negedge clk);
      maze_not_valid = 1'b0;
      push(0, 7, 0, 0, 0);
      drain();

      load(mb);
      push(0, 8, 0, 0, 0);
      drain();

      load(mb);
      legal();
      send(-1, 10, lc);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_pass", int'(pass), 0);
      chk("mid_rst_err", int'(err_code), 0);
      chk("mid_rst_len", int'(path_len), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      load(mb);
      legal();
      send(-1, 1000, lc);
      push(1, 0, 25, lc + 2, 1);
      drain();

      load(mb);
      legal();
      send(3, 1000, lc);
      push(0, 9, 25, lc + 2, 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
